// File: rtl/uart_rx_buffer_if.sv
// Byte-buffer bus between the UART receiver/consumer side and uart_rx_buffer.
// Carries the receive strobe, the drain handshake, occupancy and sticky error flags.
interface uart_rx_buffer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_en;
  logic          frame_err_in;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          frame_err;
  logic          err_clr;

  // Driver side: receiver strobe, consumer ready and host error clear.
  modport master (
    output wr_data, wr_en, frame_err_in, rd_ready, err_clr,
    input  rd_data, rd_valid, count, full, overflow, frame_err
  );

  // Buffer side.
  modport slave (
    input  wr_data, wr_en, frame_err_in, rd_ready, err_clr,
    output rd_data, rd_valid, count, full, overflow, frame_err
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT byte FIFO: drops framing-error bytes, drains via valid/ready,
// and keeps sticky overflow / framing-error flags for the host.
module uart_rx_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          frame_err_q;

  logic          empty_c;
  logic          full_c;
  logic          pop_c;
  logic          push_req_c;
  logic          push_c;
  logic          drop_c;
  logic          ferr_set_c;

  // Handshake decode from registered occupancy.
  always_comb begin
    empty_c    = (count_q == '0);
    full_c     = (count_q == CW'(DEPTH));
    pop_c      = ~empty_c & bus.rd_ready;
    push_req_c = bus.wr_en & ~bus.frame_err_in;
    push_c     = push_req_c & (~full_c | pop_c);
    drop_c     = push_req_c & full_c & ~pop_c;
    ferr_set_c = bus.wr_en & bus.frame_err_in;
  end

  // Storage, pointers and occupancy; reset clears mem so rd_data is never X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 8'h00;
      end
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else begin
      if (push_c) begin
        mem[wp] <= bus.wr_data;
        wp      <= wp + AW'(1);
      end
      if (pop_c) begin
        rp <= rp + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags: a setting event in the same cycle overrides err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
      if (ferr_set_c) begin
        frame_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data   = mem[rp];
  assign bus.rd_valid  = ~empty_c;
  assign bus.full      = full_c;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte buffer that sits directly downstream of the UART receiver. Captures each completed byte strobed out by the receiver, discards bytes flagged with a framing error, and holds accepted bytes in a first-word-fall-through FIFO. The consumer drains the FIFO through a valid/ready handshake. Sticky overflow and framing-error flags report lost data to the host.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- wr_data  input  8  received byte from UART receiver
- wr_en  input  1  one-cycle strobe: wr_data/frame_err_in valid this cycle
- frame_err_in  input  1  stop bit of the strobed byte was 0
- rd_data  output  8  head-of-FIFO byte; valid while rd_valid=1
- rd_valid  output  1  FIFO non-empty
- rd_ready  input  1  consumer accepts rd_data this cycle
- count  output  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a good byte was dropped because FIFO was full
- frame_err  output  1  sticky: a byte was discarded for framing error
- err_clr  input  1  clears overflow and frame_err

## Operation
- Storage: DEPTH×8 register array; write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH with no special case.
- pop = rd_valid & rd_ready. On pop: rp ← rp+1.
- push_req = wr_en & ~frame_err_in.
- Push accepted when push_req & (~full | pop). On accept: mem[wp] ← wr_data, wp ← wp+1.
- Full with simultaneous pop: push accepted, count stays DEPTH.
- Empty with simultaneous push: rd_valid=0 this cycle, so no pop; the byte is stored normally.
- count: +1 on accepted push only, −1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Dropped byte (push_req & full & ~pop): storage, pointers and count unchanged; overflow ← 1.
- wr_en & frame_err_in: byte discarded, no pointer or count change, frame_err ← 1. Framing error never sets overflow.
- err_clr: overflow ← 0, frame_err ← 0, unless a setting event occurs in the same cycle, in which case set wins.
- rd_valid = (count != 0). full = (count == DEPTH). Both are decoded from registered count.
- rd_data = mem[rp], combinational read of registered state, glitch-free relative to clk.
- rd_ready while rd_valid=0 has no effect.

## Timing
- Reset (rst_n=0 at rising edge): wp=0, rp=0, count=0, rd_valid=0, full=0, overflow=0, frame_err=0. rd_data is don't-care but must not be X in simulation; clear mem to 0 on reset.
- Reset has priority over every other input. A reset mid-operation drops all stored bytes.
- Write latency: wr_en at edge N makes rd_valid=1 and rd_data=byte after edge N (visible during cycle N+1).
- Read: pop at edge N moves rd_data to the next entry (or deasserts rd_valid) after edge N.
- Back-to-back: one push and one pop per cycle sustainable indefinitely.
- Sticky flags: asserted the cycle after the causing edge. They remain asserted until err_clr or reset.

## Test plan
- Reset then idle: after rst_n low for 2 cycles, release. Required: count=0, rd_valid=0, full=0, overflow=0, frame_err=0 for 10 cycles.
- Basic ordering: push 0x55, 0xA3, 0x00 with rd_ready=0, then hold rd_ready=1. Required: count reaches 3, and bytes pop in order 0x55, 0xA3, 0x00, one per cycle, then rd_valid=0.
- Full/overflow (DEPTH=16): push 0x00..0x0F, then push 0xEE with rd_ready=0. Required: full=1, count=16, overflow=1, 0xEE absent. Drain returns 0x00..0x0F. Then assert err_clr: overflow=0.
- Full with simultaneous pop: with FIFO full and head=0x00, push 0x7E while rd_ready=1. Required: overflow stays 0, count stays 16, and 0x7E is the last byte drained after pointer wrap-around.
- Framing error: push 0x41 with frame_err_in=1, then 0x42 clean. Required: frame_err=1 and only 0x42 stored. err_clr in the same cycle as another framing-error byte leaves frame_err=1.
- Reset mid-operation: 5 bytes stored and overflow=1, assert rst_n=0 for 1 cycle. Required: count=0, rd_valid=0, overflow=0 the next cycle. A subsequent push of 0x99 is the first byte read.
